// File: rtl/retire_map_table_pkg.sv
// Shared sizing parameters and register-index types for the retire map table slice.
package retire_map_table_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int ARCH_REGS            = 32;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
    localparam int ARCH_REGS_ADDR_WIDTH = $clog2(ARCH_REGS);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [ARCH_REGS_ADDR_WIDTH-1:0] arch_reg_t;

endpackage

// File: rtl/retire_map_table_if.sv
// Commit-side bus of the retire map table: ROB commit lanes in, freed registers, lookup and counter out.
interface retire_map_table_if;
    import retire_map_table_pkg::*;

    logic      [DISPATCH_WIDTH-1:0] commit_en;
    phys_reg_t [DISPATCH_WIDTH-1:0] commit_phys_rd;
    arch_reg_t [DISPATCH_WIDTH-1:0] commit_arch_rd;
    logic      [DISPATCH_WIDTH-1:0] free_en;
    phys_reg_t [DISPATCH_WIDTH-1:0] free_phys_rd;
    arch_reg_t                      lookup_arch_rd;
    phys_reg_t                      lookup_phys_rd;
    logic      [31:0]               retire_count;

    modport master (
        output commit_en, commit_phys_rd, commit_arch_rd, lookup_arch_rd,
        input  free_en, free_phys_rd, lookup_phys_rd, retire_count
    );

    modport slave (
        input  commit_en, commit_phys_rd, commit_arch_rd, lookup_arch_rd,
        output free_en, free_phys_rd, lookup_phys_rd, retire_count
    );

endinterface

// File: rtl/retire_map_table_lane_resolve.sv
// Combinational lane-ordered resolver: applies each commit lane, oldest first, to a running map copy.
module retire_lane_resolve
    import retire_map_table_pkg::*;
(
    input  phys_reg_t [ARCH_REGS-1:0]      map_cur,
    input  logic      [DISPATCH_WIDTH-1:0] commit_en,
    input  phys_reg_t [DISPATCH_WIDTH-1:0] commit_phys_rd,
    input  arch_reg_t [DISPATCH_WIDTH-1:0] commit_arch_rd,
    output phys_reg_t [ARCH_REGS-1:0]      map_nxt,
    output phys_reg_t [DISPATCH_WIDTH-1:0] old_phys,
    output logic      [DISPATCH_WIDTH-1:0] free_vld
);

    always_comb begin
        map_nxt  = map_cur;
        old_phys = '0;
        free_vld = '0;
        // A younger lane sees the older lane's write, which handles same-cycle aliasing.
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            old_phys[w] = map_nxt[commit_arch_rd[w]];
            if (commit_en[w] && (commit_arch_rd[w] != '0) &&
                (map_nxt[commit_arch_rd[w]] != commit_phys_rd[w])) begin
                map_nxt[commit_arch_rd[w]] = commit_phys_rd[w];
                free_vld[w]                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_map_table.sv
// Committed register alias table: holds the architectural map, frees superseded physical registers.
module retire_map_table
    import retire_map_table_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    retire_map_table_if.slave  bus
);

    phys_reg_t [ARCH_REGS-1:0]      map_p0;
    phys_reg_t [DISPATCH_WIDTH-1:0] old_p0;
    logic      [DISPATCH_WIDTH-1:0] vld_p0;

    phys_reg_t [ARCH_REGS-1:0]      map_p1;
    phys_reg_t [DISPATCH_WIDTH-1:0] free_phys_p1;
    logic      [DISPATCH_WIDTH-1:0] vld_p1;
    logic      [31:0]               retire_count_p1;

    function automatic logic [31:0] popcount(input logic [DISPATCH_WIDTH-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    retire_lane_resolve u_resolve (
        .map_cur        (map_p1),
        .commit_en      (bus.commit_en),
        .commit_phys_rd (bus.commit_phys_rd),
        .commit_arch_rd (bus.commit_arch_rd),
        .map_nxt        (map_p0),
        .old_phys       (old_p0),
        .free_vld       (vld_p0)
    );

    // p0 -> p1: commit resolution registered into map, free outputs and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_p1[i] <= phys_reg_t'(i);
            end
            vld_p1          <= '0;
            free_phys_p1    <= '0;
            retire_count_p1 <= '0;
        end else begin
            map_p1          <= map_p0;
            vld_p1          <= vld_p0;
            retire_count_p1 <= retire_count_p1 + popcount(bus.commit_en);
            // Lanes that free nothing keep their last reported register.
            for (int w = 0; w < DISPATCH_WIDTH; w++) begin
                if (vld_p0[w]) begin
                    free_phys_p1[w] <= old_p0[w];
                end
            end
        end
    end

    assign bus.free_en        = vld_p1;
    assign bus.free_phys_rd   = free_phys_p1;
    assign bus.retire_count   = retire_count_p1;
    assign bus.lookup_phys_rd = map_p1[bus.lookup_arch_rd];

endmodule

// File: tb/tb_retire_map_table.sv
// Directed bench for retire_map_table: reference map model feeds a scoreboard of expected frees.
module tb_retire_map_table;
    import retire_map_table_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retire_map_table_if bus ();

    retire_map_table dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0]  en;
        phys_reg_t   f0;
        phys_reg_t   f1;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          mdl_map[ARCH_REGS];
    phys_reg_t   last_free[2];
    logic [31:0] mdl_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) mdl_map[i] = i;
        last_free[0] = '0;
        last_free[1] = '0;
        mdl_cnt = '0;
        sb.delete();
    endtask

    task automatic drive(input logic [1:0] en, input int a0, input int p0, input int a1, input int p1);
        bus.commit_en         = en;
        bus.commit_arch_rd[0] = arch_reg_t'(a0);
        bus.commit_phys_rd[0] = phys_reg_t'(p0);
        bus.commit_arch_rd[1] = arch_reg_t'(a1);
        bus.commit_phys_rd[1] = phys_reg_t'(p1);
    endtask

    task automatic commit(input logic [1:0] en, input int a0, input int p0, input int a1, input int p1);
        exp_t e;
        int   a, p;
        @(negedge clk);
        drive(en, a0, p0, a1, p1);
        e.en = 2'b00;
        for (int w = 0; w < 2; w++) begin
            a = (w == 0) ? a0 : a1;
            p = (w == 0) ? p0 : p1;
            if (en[w]) mdl_cnt = mdl_cnt + 1;
            if (en[w] && a != 0 && mdl_map[a] != p) begin
                e.en[w]      = 1'b1;
                last_free[w] = phys_reg_t'(mdl_map[a]);
                mdl_map[a]   = p;
            end
        end
        e.f0  = last_free[0];
        e.f1  = last_free[1];
        e.cnt = mdl_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.commit_en = 2'b00;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("free_en", 32'(bus.free_en), 32'(e.en));
            check("free_phys0", 32'(bus.free_phys_rd[0]), 32'(e.f0));
            check("free_phys1", 32'(bus.free_phys_rd[1]), 32'(e.f1));
            check("retire_count", bus.retire_count, e.cnt);
        end
    endtask

    task automatic look(input int a, input int exp);
        bus.lookup_arch_rd = arch_reg_t'(a);
        #1;
        check($sformatf("lookup%0d", a), 32'(bus.lookup_phys_rd), 32'(exp));
    endtask

    initial begin
        drive(2'b00, 0, 0, 0, 0);
        bus.lookup_arch_rd = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_free_en", 32'(bus.free_en), 32'd0);
        check("rst_count", bus.retire_count, 32'd0);
        for (int i = 0; i < ARCH_REGS; i++) look(i, i);
        @(negedge clk);
        rst_n = 1'b1;

        // Single commit
        commit(2'b01, 5, 40, 0, 0);
        check("single_free", 32'(bus.free_phys_rd[0]), 32'd5);
        look(5, 40);

        // Dual distinct commit
        commit(2'b11, 3, 33, 7, 34);
        check("dual_en", 32'(bus.free_en), 32'd3);
        look(3, 33);
        look(7, 34);

        // Same-cycle alias
        commit(2'b11, 9, 41, 9, 42);
        check("alias_f1", 32'(bus.free_phys_rd[1]), 32'd41);
        look(9, 42);

        // x0 and sparse lanes
        commit(2'b01, 0, 50, 0, 0);
        look(0, 0);
        commit(2'b10, 0, 0, 4, 51);
        check("sparse_f1", 32'(bus.free_phys_rd[1]), 32'd4);
        look(4, 51);

        // Idle cycle holds free_phys_rd, degenerate commit frees nothing
        commit(2'b00, 0, 0, 0, 0);
        commit(2'b01, 5, 40, 0, 0);
        look(5, 40);

        // Async reset mid-stream
        commit(2'b11, 10, 20, 11, 21);
        @(negedge clk);
        drive(2'b11, 12, 22, 13, 23);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_free_en", 32'(bus.free_en), 32'd0);
        check("arst_free0", 32'(bus.free_phys_rd[0]), 32'd0);
        check("arst_free1", 32'(bus.free_phys_rd[1]), 32'd0);
        check("arst_count", bus.retire_count, 32'd0);
        look(5, 5);
        look(9, 9);
        look(10, 10);
        @(posedge clk);
        #1;
        check("arst_hold_count", bus.retire_count, 32'd0);
        look(12, 12);
        @(negedge clk);
        bus.commit_en = 2'b00;
        rst_n = 1'b1;
        model_reset();

        commit(2'b01, 6, 60, 0, 0);
        look(6, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
